// File: rtl/mem_rr_arbiter.sv
`timescale 1ns/1ps
// Two-master round-robin arbiter for the native valid/ready memory bus.
// Grant is held for a whole transfer; a watchdog force-completes a silent slave.
//
// state | meaning
// IDLE  | no transfer; arbitrate between pending masters (costs one cycle)
// BUSY  | granted master routed to the slave until ready, timeout or abort
module mem_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        timeout
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_grant;
  logic          r_timeout;
  logic [CW-1:0] r_count;
  logic          w_gvalid;
  logic          w_done;
  logic          w_force;
  logic          w_grant_next;

  assign w_gvalid = r_grant ? m1_valid : m0_valid;
  assign w_done   = (r_state == S_BUSY) && w_gvalid && s_ready;
  // A slave ack in the last watchdog cycle wins over the forced completion.
  assign w_force  = (TIMEOUT_CYCLES != 0) && (r_state == S_BUSY) && w_gvalid &&
                    !s_ready && (r_count == CNT_LAST);

  always_comb begin
    w_grant_next = r_grant;
    if (m0_valid && m1_valid) w_grant_next = ~r_grant;
    else if (m1_valid)        w_grant_next = 1'b1;
    else if (m0_valid)        w_grant_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (m0_valid || m1_valid) w_state_next = S_BUSY;
      S_BUSY:  if (!w_gvalid || w_done || w_force) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant   <= 1'b1;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == S_IDLE && (m0_valid || m1_valid)) begin
        r_grant <= w_grant_next;
        r_count <= '0;
      end else if (r_state == S_BUSY && r_count != CNT_MAX) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  always_comb begin
    s_valid  = 1'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    s_instr  = r_grant ? m1_instr : m0_instr;
    s_addr   = r_grant ? m1_addr  : m0_addr;
    s_wdata  = r_grant ? m1_wdata : m0_wdata;
    s_wstrb  = r_grant ? m1_wstrb : m0_wstrb;
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    if (!reset && r_state == S_BUSY) begin
      s_valid = w_gvalid;
      if (w_done || w_force) begin
        if (r_grant) m1_ready = 1'b1;
        else         m0_ready = 1'b1;
      end
    end
    if (w_force) begin
      if (r_grant) m1_rdata = TIMEOUT_RDATA;
      else         m0_rdata = TIMEOUT_RDATA;
    end
  end

  assign grant   = r_grant;
  assign timeout = r_timeout;

endmodule
